// File: rtl/rv_pkg.sv
// Shared encodings and types for the rv_multicycle_core integer datapath.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
  } alu_op_t;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  // funct3 alone selects the operation for funct7=0 R-type and for OP-IMM.
  function automatic alu_op_t base_op(input logic [2:0] funct3);
    case (funct3)
      F3_ADD:  return ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return ALU_SRL;
      F3_OR:   return ALU_OR;
      F3_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational integer ALU; shifts use the low log2(XLEN) bits of b.
// MUL is only built when RV_MUL_EN is defined.
module rv_alu
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: result = XLEN'(a < b);
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
`ifdef RV_MUL_EN
      ALU_MUL:  result = a * b;
`endif
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV32I/RV64I core for R-type and OP-IMM instructions over a req/valid fetch port.
// Define RV_MUL_EN to add R-type MUL with a two-cycle EXECUTE.
module rv_multicycle_core
  import rv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [XLEN-1:0] Out,
  output logic            retire,
  output logic            illegal
);

  localparam int          IDXW          = $clog2(NREGS);
  localparam int          SHW           = $clog2(XLEN);
  localparam logic [11:0] SHAMT_HI_MASK = 12'hFFF << SHW;

  state_t          state, next_state;
  logic [XLEN-1:0] pc;
  logic [31:0]     ir;
  logic [XLEN-1:0] a_q, b_q, result_q;
  alu_op_t         op_q;
  logic [XLEN-1:0] regs [NREGS];

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [11:0]     imm12;
  logic [XLEN-1:0] imm_sext, rs1_val, rs2_val, alu_result;
  alu_op_t         dec_op;
  logic            dec_use_imm, dec_illegal;

`ifdef RV_MUL_EN
  logic            mul_done;
`endif

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign funct3   = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign funct7   = ir[31:25];
  assign imm12    = ir[31:20];
  assign imm_sext = {{(XLEN-12){imm12[11]}}, imm12};

  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1[IDXW-1:0]];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2[IDXW-1:0]];

  assign imem_req  = (state == S_FETCH) && !reset;
  assign imem_addr = pc;

  always_comb begin
    dec_op      = ALU_ADD;
    dec_use_imm = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        case (funct7)
          F7_BASE: dec_op = base_op(funct3);
          F7_ALT: begin
            if (funct3 == F3_ADD)     dec_op = ALU_SUB;
            else if (funct3 == F3_SR) dec_op = ALU_SRA;
            else                      dec_illegal = 1'b1;
          end
          F7_MULDIV: begin
`ifdef RV_MUL_EN
            if (funct3 == F3_ADD) dec_op = ALU_MUL;
            else                  dec_illegal = 1'b1;
`else
            dec_illegal = 1'b1;
`endif
          end
          default: dec_illegal = 1'b1;
        endcase
        if ({1'b0, rs2} >= 6'(NREGS)) dec_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_use_imm = 1'b1;
        dec_op      = base_op(funct3);
        // Immediate shifts: only bit 30 (SRAI) may be set above the shift amount.
        if (funct3 == F3_SLL && (imm12 & SHAMT_HI_MASK) != 12'h000) dec_illegal = 1'b1;
        if (funct3 == F3_SR) begin
          if ((imm12 & SHAMT_HI_MASK) == 12'h400)      dec_op = ALU_SRA;
          else if ((imm12 & SHAMT_HI_MASK) != 12'h000) dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    if ({1'b0, rd} >= 6'(NREGS) || {1'b0, rs1} >= 6'(NREGS)) dec_illegal = 1'b1;
  end

  rv_alu #(.XLEN(XLEN)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result)
  );

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:     if (imem_valid) next_state = S_DECODE;
      S_DECODE:    next_state = dec_illegal ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
`ifdef RV_MUL_EN
        // MUL holds EXECUTE a second cycle so the product path gets two clocks.
        if (op_q == ALU_MUL && !mul_done) next_state = S_EXECUTE;
        else                              next_state = S_WRITEBACK;
`else
        next_state = S_WRITEBACK;
`endif
      end
      S_WRITEBACK: next_state = S_FETCH;
      S_HALT:      next_state = S_HALT;
      default:     next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      ir       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= ALU_ADD;
      result_q <= '0;
      Out      <= '0;
      retire   <= 1'b0;
      illegal  <= 1'b0;
`ifdef RV_MUL_EN
      mul_done <= 1'b0;
`endif
      // NOTE: the register file is architecturally zeroed on reset, so it is built from flops, not RAM.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      retire <= 1'b0;
`ifdef RV_MUL_EN
      mul_done <= (state == S_EXECUTE) && (op_q == ALU_MUL) && !mul_done;
`endif
      case (state)
        S_FETCH: if (imem_valid) ir <= imem_rdata;
        S_DECODE: begin
          a_q  <= rs1_val;
          b_q  <= dec_use_imm ? imm_sext : rs2_val;
          op_q <= dec_op;
          if (dec_illegal) illegal <= 1'b1;
        end
        S_EXECUTE: result_q <= alu_result;
        S_WRITEBACK: begin
          if (rd != 5'd0) begin
            regs[rd[IDXW-1:0]] <= result_q;
            Out                <= result_q;
          end
          pc     <= pc + XLEN'(4);
          retire <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rv_multicycle_core.md
Name: rv_multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle R-type datapath.
- Executes RV32I R-type and OP-IMM (I-type ALU) instructions.
- Fetches over a request/valid instruction-memory handshake and tolerates any fetch latency.
- Exposes the last ALU result, a retire strobe and a sticky illegal-instruction flag for the top level and for checking.

Parameters:
- XLEN, 32, datapath and register width; legal values 32 or 64.
- NREGS, 32, number of architectural registers; 16 (RV32E) or 32; x0 hard-wired to zero.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; held high until accepted.
- imem_addr  output  XLEN  fetch address (current PC).
- imem_rdata  input  32  instruction word; valid when imem_valid=1.
- imem_valid  input  1  fetch response strobe.
- Out  output  XLEN  last written-back ALU result.
- retire  output  1  one-cycle pulse per retired instruction.
- illegal  output  1  sticky unsupported-instruction flag.

Behaviour:
- Reset values: pc=RESET_PC, state=FETCH, all registers 0, Out=0, retire=0, illegal=0, imem_req=0.
  - Reset has priority in any state, including mid-fetch.
  - A pending fetch is abandoned; an imem_valid arriving during reset is ignored.
- FSM states: FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_valid=1, latch imem_rdata into ir and go to DECODE. Otherwise stay.
  - imem_req drops in the cycle after acceptance.
- DECODE:
  - Read rs1=ir[19:15] and rs2=ir[24:20] into operand latches.
  - Build the sign-extended I-immediate from ir[31:20].
  - Any of the following sets illegal=1 and goes to HALT; otherwise go to EXECUTE:
    - unsupported opcode, funct3 or funct7;
    - register index >= NREGS.
- EXECUTE: the ALU computes the result into a latch.
- WRITEBACK:
  - If rd!=0, write the result to rd and update Out.
  - If rd=0, the register file and Out are unchanged.
  - pc += 4 (wraps modulo 2^XLEN). retire=1 for this cycle only. Go to FETCH.
- HALT: terminal until reset. imem_req=0, illegal stays 1, no register writes.
- Latency: 4 cycles per instruction when imem_valid arrives in the first FETCH cycle; add one cycle per wait cycle.
- Supported R-type (opcode 0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - SUB and SRA are selected by funct7=0100000.
- Supported OP-IMM (opcode 0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - For SLLI/SRLI/SRAI, upper immediate bits other than bit 30 (SRAI) must be zero, otherwise the instruction is illegal.
- Width rules:
  - Shift amount is the low log2(XLEN) bits.
  - Arithmetic is modulo 2^XLEN.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned with the sign-extended immediate.
  - Comparison results zero-extend to XLEN.
- Register file: one write port, two read ports. A write in WRITEBACK is visible to the next instruction's DECODE; no bypass is needed.
- Reads of x0 always return 0.

Optional Feature:
- Macro: RV_MUL_EN.
- Defined: R-type funct7=0000001 with funct3=000 executes MUL (low XLEN bits of the product, signed/unsigned-agnostic).
  - EXECUTE then lasts 2 cycles to register the product; retire timing shifts by one cycle.
  - Other funct3 values with funct7=0000001 remain illegal.
- Undefined: any funct7=0000001 is illegal.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants OPC_OP and OPC_OP_IMM;
  - funct3/funct7 constants;
  - alu_op_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL);
  - state_t enum.
- Sub-module rv_alu (purely combinational):
  - parametrised by XLEN;
  - inputs a, b, alu_op_t; output result.
  - Register file and FSM stay in the top module.

Test Plan:
- Reset, then ADDI x1,x0,5 with imem_valid arriving on the first request cycle -> retire 4 cycles after fetch start; Out=5; x1=5; next imem_addr=4.
- ADDI x1,x0,-1; then SRLI x2,x1,4 (XLEN=32) -> Out=32'h0FFF_FFFF. SRAI x3,x1,4 -> Out=32'hFFFF_FFFF. SLTU x4,x0,x1 -> Out=1.
- ADD x0,x1,x1 -> retire pulses; x0 reads 0; Out unchanged.
- imem_valid delayed 3 cycles -> imem_req and imem_addr held stable throughout; retire occurs 3 cycles later. Reset asserted during the wait -> pc=RESET_PC and no retire.
- Opcode 0000011 (load) -> illegal=1 after DECODE; imem_req stays 0; illegal persists until reset.
- MUL x5,x1,x2 with x1=7, x2=-3 -> Out=32'hFFFF_FFEB with RV_MUL_EN defined; illegal=1 without it.
